instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Front-end fetch block that produces the instruction stream consumed by the instruction decoder. It generates fetch addresses, runs a request/grant/response handshake with instruction memory, and buffers returned words with their PCs in a small in-order queue. It presents one instruction per cycle to decode, with `flush_out` driving the decoder's flush input so the decoder inserts a NOP (`32'h00000013`) whenever no valid instruction is available or the stream is being redirected.

## Interface
Parameters:
- `DEPTH`, 4: queue entries and maximum in-flight requests; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word aligned.

Ports:
- `clk_in`  in  1  single clock; all state updates on its rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `imem_req_out`  out  1  fetch request valid.
- `imem_addr_out`  out  32  fetch address, word aligned.
- `imem_gnt_in`  in  1  request accepted this cycle.
- `imem_rvalid_in`  in  1  response valid; responses return in request order, ≥1 cycle after grant.
- `imem_rdata_in`  in  32  instruction word.
- `redirect_in`  in  1  branch/jump/trap redirect.
- `redirect_pc_in`  in  32  redirect target.
- `stall_in`  in  1  decode not accepting this cycle.
- `instr_out`  out  32  head instruction.
- `pc_out`  out  32  PC of `instr_out`.
- `flush_out`  out  1  no valid instruction this cycle; connects to decoder flush.
- `misaligned_out`  out  1  one-cycle pulse: redirect target had `[1:0]!=0`.

## Operation
- State: `fetch_pc`, queue of `{pc, instr}` (count 0..DEPTH), `inflight` (granted requests not yet responded, 0..DEPTH), `discard` (oldest in-flight responses to drop, ≤ inflight).
- Issue: `imem_req_out = !rst_in && !redirect_in && (count + inflight < DEPTH)`; `imem_addr_out = fetch_pc`. On `req && gnt`: `fetch_pc += 4` (wraps modulo 2^32), `inflight++`.
- Response: on `imem_rvalid_in`, `inflight--`; if `discard>0`, `discard--` and data dropped; otherwise push `{pc of that request, imem_rdata_in}`. Response PCs tracked by a push-side PC register that starts at the fetch address of the first live request.
- Pop: when `count>0 && !stall_in && !redirect_in`, head leaves queue.
- `flush_out = (count==0) || redirect_in`; `instr_out`/`pc_out` show the head entry (`instr_out` = NOP, `pc_out` = last value when empty).
- Redirect: queue cleared; `fetch_pc` and push PC ← `{redirect_pc_in[31:2],2'b00}`; `discard` ← all in-flight requests not responded in this cycle (a response arriving the same cycle is dropped); no request issued in the redirect cycle; `misaligned_out` = `|redirect_pc_in[1:0]` for that cycle.
- Credit rule guarantees room for every response; a push to a full queue never happens (assertion).
- Simultaneous push and pop: both occur, count unchanged.

## Timing
- Reset (any cycle, including mid-transaction): count, inflight, discard ← 0; `fetch_pc` ← `RESET_PC`; outputs during/after reset: `imem_req_out=0` while `rst_in`, `flush_out=1`, `instr_out=32'h00000013`, `pc_out=RESET_PC`, `misaligned_out=0`. Memory is reset alongside; no pre-reset responses arrive afterwards.
- First request in the first cycle with `rst_in=0`.
- Latency: response at edge N → visible on `instr_out` in cycle N+1 (registered queue, combinational head read).
- Zero-wait memory (gnt always 1, rvalid one cycle after grant): sustained one instruction per cycle with `stall_in=0`.
- Redirect at cycle N → earliest new request in cycle N+1; with zero-wait memory, target instruction on `instr_out` in cycle N+3.

## Structure
- Shared package `riscv_pkg`: `NOP_INSTR = 32'h00000013`, `XLEN = 32`, `INSTR_W = 32`, default `RESET_PC`.
- Sub-module `fetch_fifo`: synchronous FIFO of `{pc, instr}` with parameter `DEPTH`, push/pop/clear, count, and head output; the top level holds PC generation, credit, and discard logic.

## Test plan
- Reset then release: `imem_req_out=0` during reset; first cycle after, `imem_req_out=1`, `imem_addr_out=0x0`, `flush_out=1` until the first response.
- Zero-wait memory returning `addr+0x1000` as data, `stall_in=0`: `pc_out` 0x0,0x4,0x8… on consecutive cycles with `instr_out`=0x1000,0x1004,…; `flush_out=0` from cycle 3 on.
- `stall_in=1` held: exactly 4 grants, then `imem_req_out=0`, head stays at pc 0x0; release gives 0x0,0x4,0x8,0xC in order with no loss.
- Memory latency 3, two requests in flight, redirect to 0x100: both stale responses dropped; next `flush_out=0` cycle shows `pc_out=0x100`.
- Redirect to 0x102: `misaligned_out` pulses once; `imem_addr_out=0x100` next cycle.
- Reset asserted with a full queue and 2 in flight: next cycle count 0, `flush_out=1`, `instr_out=0x00000013`; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the fetch queue entry type.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of {pc, instr} entries with clear; the head is read combinationally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         i_push,
    input  fetch_entry_t                 i_entry,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output fetch_entry_t                 o_head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk_in) begin
        if (rst_in || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // The credit rule upstream reserves a slot for every granted request.
    a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        !(i_push && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: PC generation, imem request credit, stale-response discard and
// an in-order instruction queue feeding decode.
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    output logic               imem_req_out,
    output logic [XLEN-1:0]    imem_addr_out,
    input  logic               imem_gnt_in,
    input  logic               imem_rvalid_in,
    input  logic [INSTR_W-1:0] imem_rdata_in,
    input  logic               redirect_in,
    input  logic [XLEN-1:0]    redirect_pc_in,
    input  logic               stall_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [XLEN-1:0]    pc_out,
    output logic               flush_out,
    output logic               misaligned_out
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_push_pc;
    logic [XLEN-1:0] r_pc_hold;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_credit;
    logic [XLEN-1:0] w_target;
    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;
    logic            w_req;
    logic            w_fire;
    logic            w_dropping;
    logic            w_push;
    logic            w_pop;
    logic            w_has_head;

    assign w_target   = {redirect_pc_in[XLEN-1:2], 2'b00};
    assign w_credit   = {1'b0, w_count} + {1'b0, r_inflight};
    assign w_req      = !rst_in && !redirect_in && (w_credit < (CW + 1)'(DEPTH));
    assign w_fire     = w_req && imem_gnt_in;
    assign w_dropping = (r_discard != '0);
    assign w_push     = imem_rvalid_in && !w_dropping && !redirect_in && !rst_in;
    assign w_has_head = (w_count != '0) && !rst_in;
    assign w_pop      = w_has_head && !stall_in && !redirect_in;

    assign w_entry.pc    = r_push_pc;
    assign w_entry.instr = imem_rdata_in;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_clear (redirect_in),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fetch_pc <= RESET_PC;
            r_push_pc  <= RESET_PC;
            r_pc_hold  <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_fire) - CW'(imem_rvalid_in);
            if (w_has_head) r_pc_hold <= w_head.pc;
            if (redirect_in) begin
                r_fetch_pc <= w_target;
                r_push_pc  <= w_target;
                // A response landing this cycle is already dropped, so it is not counted.
                r_discard  <= r_inflight - CW'(imem_rvalid_in);
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_push_pc  <= r_push_pc + 32'd4;
                if (imem_rvalid_in && w_dropping) r_discard <= r_discard - CW'(1);
            end
        end
    end

    assign imem_req_out   = w_req;
    assign imem_addr_out  = r_fetch_pc;
    assign flush_out      = !w_has_head || redirect_in;
    assign instr_out      = w_has_head ? w_head.instr : NOP_INSTR;
    assign pc_out         = rst_in ? RESET_PC : (w_has_head ? w_head.pc : r_pc_hold);
    assign misaligned_out = !rst_in && redirect_in && (redirect_pc_in[1:0] != 2'b00);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue with a latency-configurable in-order imem model.
module tb_instr_fetch_queue;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] rpc_in;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        mis;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .imem_req_out   (req),
        .imem_addr_out  (addr),
        .imem_gnt_in    (gnt),
        .imem_rvalid_in (rvalid),
        .imem_rdata_in  (rdata),
        .redirect_in    (redirect),
        .redirect_pc_in (rpc_in),
        .stall_in       (stall),
        .instr_out      (instr),
        .pc_out         (pc),
        .flush_out      (flush),
        .misaligned_out (mis)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    int grants   = 0;
    int pops     = 0;

    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] exp_pc_q[$];

    logic        s_req;
    logic        s_flush;
    logic        s_mis;
    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic [31:0] s_pc;

    // One clock cycle: drive memory response, sample at negedge, score pops, log grants.
    task automatic step();
        logic [31:0] e;
        if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
            exp_pc_q.delete();
        end
        if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_addr_q[0] + 32'h1000;
        end else begin
            rvalid = 1'b0;
            rdata  = 32'hdead_beef;
        end
        @(negedge clk);
        s_req   = req;
        s_addr  = addr;
        s_flush = flush;
        s_mis   = mis;
        s_instr = instr;
        s_pc    = pc;
        if (!flush && !stall) begin
            pops++;
            checks++;
            if (exp_pc_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, required no instruction",
                         pc, instr);
            end else begin
                e = exp_pc_q.pop_front();
                if (pc !== e || instr !== e + 32'h1000) begin
                    failures++;
                    $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             pc, instr, e, e + 32'h1000);
                end
            end
        end
        if (rvalid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (redirect) exp_pc_q.delete();
        if (req && gnt) begin
            mem_addr_q.push_back(addr);
            mem_due_q.push_back(cyc + lat);
            exp_pc_q.push_back(addr);
            grants++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        gnt      = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (!s_flush) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; gnt = 1'b1; rpc_in = 32'h0; lat = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (s_req !== 1'b0 || s_flush !== 1'b1 || s_instr !== NOP_INSTR || s_pc !== RPC ||
                s_mis !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: got req=%b flush=%b instr=%h pc=%h mis=%b, required 0 1 %h %h 0",
                         s_req, s_flush, s_instr, s_pc, s_mis, NOP_INSTR, RPC);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (s_req !== 1'b1) begin
            failures++; $display("FAIL first_req: got %b, required 1", s_req);
        end
        checks++;
        if (s_addr !== RPC) begin
            failures++; $display("FAIL first_addr: got %h, required %h", s_addr, RPC);
        end
        checks++;
        if (s_flush !== 1'b1) begin
            failures++; $display("FAIL first_flush: got %b, required 1", s_flush);
        end
        step();
        checks++;
        if (s_flush !== 1'b1) begin
            failures++; $display("FAIL resp_cycle_flush: got %b, required 1", s_flush);
        end
        step();
        checks++;
        if (s_flush !== 1'b0 || s_pc !== RPC || s_instr !== RPC + 32'h1000) begin
            failures++;
            $display("FAIL first_visible: got flush=%b pc=%h instr=%h, required 0 %h %h",
                     s_flush, s_pc, s_instr, RPC, RPC + 32'h1000);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        int          p0;
        want = RPC + 32'h4;
        p0   = pops;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (s_flush !== 1'b0 || s_pc !== want || s_instr !== want + 32'h1000) begin
                failures++;
                $display("FAIL stream: got flush=%b pc=%h instr=%h, required 0 %h %h",
                         s_flush, s_pc, s_instr, want, want + 32'h1000);
            end
            want = want + 32'h4;
        end
        checks++;
        if (pops - p0 != 12) begin
            failures++; $display("FAIL stream_rate: got %0d pops, required 12", pops - p0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] want;
        int          g0;
        do_reset();
        lat   = 1;
        stall = 1'b1;
        g0    = grants;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (grants - g0 != 4) begin
            failures++; $display("FAIL stall_grants: got %0d, required 4", grants - g0);
        end
        checks++;
        if (s_req !== 1'b0) begin
            failures++; $display("FAIL stall_req: got %b, required 0", s_req);
        end
        checks++;
        if (s_flush !== 1'b0 || s_pc !== RPC || s_instr !== RPC + 32'h1000) begin
            failures++;
            $display("FAIL stall_head: got flush=%b pc=%h instr=%h, required 0 %h %h",
                     s_flush, s_pc, s_instr, RPC, RPC + 32'h1000);
        end
        stall = 1'b0;
        want  = RPC;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (s_flush !== 1'b0 || s_pc !== want || s_instr !== want + 32'h1000) begin
                failures++;
                $display("FAIL stall_release: got flush=%b pc=%h instr=%h, required 0 %h %h",
                         s_flush, s_pc, s_instr, want, want + 32'h1000);
            end
            want = want + 32'h4;
        end
    endtask

    task automatic test_redirect_stale();
        bit ok;
        do_reset();
        lat = 3;
        step();
        step();
        gnt = 1'b0;
        step();
        redirect = 1'b1;
        rpc_in   = 32'h0000_0100;
        step();
        checks++;
        if (s_req !== 1'b0 || s_mis !== 1'b0 || s_flush !== 1'b1) begin
            failures++;
            $display("FAIL redirect_cycle: got req=%b mis=%b flush=%b, required 0 0 1",
                     s_req, s_mis, s_flush);
        end
        redirect = 1'b0;
        gnt      = 1'b1;
        wait_valid(20, ok);
        checks++;
        if (!ok || s_pc !== 32'h100 || s_instr !== 32'h1100) begin
            failures++;
            $display("FAIL redirect_target: got seen=%b pc=%h instr=%h, required 1 00000100 00001100",
                     ok, s_pc, s_instr);
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        do_reset();
        lat = 1;
        for (int i = 0; i < 3; i++) step();
        redirect = 1'b1;
        rpc_in   = 32'h0000_0102;
        step();
        checks++;
        if (s_mis !== 1'b1 || s_req !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_pulse: got mis=%b req=%b, required 1 0", s_mis, s_req);
        end
        redirect = 1'b0;
        step();
        checks++;
        if (s_mis !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100) begin
            failures++;
            $display("FAIL misaligned_next: got mis=%b req=%b addr=%h, required 0 1 00000100",
                     s_mis, s_req, s_addr);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || s_pc !== 32'h100 || s_instr !== 32'h1100) begin
            failures++;
            $display("FAIL misaligned_target: got seen=%b pc=%h instr=%h, required 1 00000100 00001100",
                     ok, s_pc, s_instr);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        do_reset();
        lat   = 3;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (s_req !== 1'b0 || s_flush !== 1'b1 || s_instr !== NOP_INSTR) begin
            failures++;
            $display("FAIL midreset_during: got req=%b flush=%b instr=%h, required 0 1 %h",
                     s_req, s_flush, s_instr, NOP_INSTR);
        end
        rst   = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (s_flush !== 1'b1 || s_instr !== NOP_INSTR || s_pc !== RPC) begin
            failures++;
            $display("FAIL midreset_after: got flush=%b instr=%h pc=%h, required 1 %h %h",
                     s_flush, s_instr, s_pc, NOP_INSTR, RPC);
        end
        checks++;
        if (s_req !== 1'b1 || s_addr !== RPC) begin
            failures++;
            $display("FAIL midreset_restart: got req=%b addr=%h, required 1 %h", s_req, s_addr, RPC);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || s_pc !== RPC || s_instr !== RPC + 32'h1000) begin
            failures++;
            $display("FAIL midreset_first: got seen=%b pc=%h instr=%h, required 1 %h %h",
                     ok, s_pc, s_instr, RPC, RPC + 32'h1000);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stale();
        test_misaligned();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
